// File: rtl/fx_cmd_sequencer.sv
// Byte-stream front end for the clipping effect: splits RX bytes into samples and
// escaped config commands, runs each sample through the effect and hands it to TX.
module fx_cmd_sequencer #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int DEFAULT_CLIP   = 200,
    parameter int FX_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 1000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_byte,
    output logic       o_fx_valid,
    output logic [7:0] o_fx_byte,
    output logic       o_clip_en,
    output logic [7:0] o_clip_level,
    input  logic [7:0] i_fx_byte,
    output logic       o_tx_start,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_busy,
    output logic       o_overrun,
    output logic       o_cmd_err,
    output logic       o_busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LW = $clog2(FX_LATENCY + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(FX_LATENCY);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ESC     = 3'd1,
        ST_ARG     = 3'd2,
        ST_WAIT_FX = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          fx_valid_q, fx_valid_d;
    logic [7:0]    fx_byte_q, fx_byte_d;
    logic          clip_en_q, clip_en_d;
    logic [7:0]    clip_level_q, clip_level_d;
    logic [7:0]    tx_byte_q, tx_byte_d;
    logic          overrun_q, overrun_d;
    logic          cmd_err_q, cmd_err_d;
    logic [1:0]    opcode_q, opcode_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic          tx_start_s;
    logic          timeout_s;

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            fx_valid_q   <= 1'b0;
            fx_byte_q    <= 8'h00;
            clip_en_q    <= 1'b1;
            clip_level_q <= 8'(DEFAULT_CLIP);
            tx_byte_q    <= 8'h00;
            overrun_q    <= 1'b0;
            cmd_err_q    <= 1'b0;
            opcode_q     <= 2'd0;
            to_cnt_q     <= '0;
            lat_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            fx_valid_q   <= fx_valid_d;
            fx_byte_q    <= fx_byte_d;
            clip_en_q    <= clip_en_d;
            clip_level_q <= clip_level_d;
            tx_byte_q    <= tx_byte_d;
            overrun_q    <= overrun_d;
            cmd_err_q    <= cmd_err_d;
            opcode_q     <= opcode_d;
            to_cnt_q     <= to_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    // Next-state logic: parser, effect sequencing and TX handshake
    always_comb begin
        state_d      = state_q;
        fx_valid_d   = 1'b0;
        fx_byte_d    = fx_byte_q;
        clip_en_d    = clip_en_q;
        clip_level_d = clip_level_q;
        tx_byte_d    = tx_byte_q;
        overrun_d    = overrun_q;
        cmd_err_d    = cmd_err_q;
        opcode_d     = opcode_q;
        to_cnt_d     = to_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        tx_start_s   = (state_q == ST_SEND) && !i_tx_busy;
        timeout_s    = (to_cnt_q == TO_LAST);

        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_byte == 8'hFF) begin
                        state_d  = ST_ESC;
                        to_cnt_d = '0;
                    end else begin
                        fx_byte_d  = i_rx_byte;
                        fx_valid_d = 1'b1;
                        lat_cnt_d  = '0;
                        state_d    = ST_WAIT_FX;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ESC: begin
                if (i_rx_valid) begin
                    to_cnt_d = '0;
                    case (i_rx_byte)
                        8'hFF: begin
                            fx_byte_d  = 8'hFF;
                            fx_valid_d = 1'b1;
                            lat_cnt_d  = '0;
                            state_d    = ST_WAIT_FX;
                        end
                        8'h01, 8'h02: begin
                            opcode_d = i_rx_byte[1:0];
                            state_d  = ST_ARG;
                        end
                        8'h03: begin
                            overrun_d = 1'b0;
                            cmd_err_d = 1'b0;
                            state_d   = ST_IDLE;
                        end
                        default: begin
                            cmd_err_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    endcase
                end else if (timeout_s) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ST_ARG: begin
                if (i_rx_valid) begin
                    to_cnt_d = '0;
                    state_d  = ST_IDLE;
                    if (opcode_q == 2'd1) begin
                        clip_en_d = i_rx_byte[0];
                    end else begin
                        clip_level_d = i_rx_byte;
                    end
                end else if (timeout_s) begin
                    cmd_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            ST_WAIT_FX: begin
                overrun_d = overrun_q | i_rx_valid;
                // lat_cnt_q == 0 is the o_fx_valid cycle; effect output is valid FX_LATENCY later
                if (lat_cnt_q == LAT_LAST) begin
                    tx_byte_d = clip_en_q ? i_fx_byte : fx_byte_q;
                    state_d   = ST_SEND;
                end else begin
                    lat_cnt_d = lat_cnt_q + LW'(1);
                end
            end
            ST_SEND: begin
                overrun_d = overrun_q | i_rx_valid;
                if (tx_start_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_fx_valid   = fx_valid_q;
    assign o_fx_byte    = fx_byte_q;
    assign o_clip_en    = clip_en_q;
    assign o_clip_level = clip_level_q;
    assign o_tx_byte    = tx_byte_q;
    assign o_overrun    = overrun_q;
    assign o_cmd_err    = cmd_err_q;
    assign o_busy       = (state_q != ST_IDLE);
    // Start is combinational on busy; masked so a reset in SEND never launches a byte
    assign o_tx_start   = tx_start_s && !i_rst;

endmodule

// File: tb/tb_fx_cmd_sequencer.sv
// Self-checking bench: directed scenarios plus random byte streams, checked every
// cycle against a timestamp-based protocol model and a modelled clipping effect.
module tb_fx_cmd_sequencer;

    localparam int FX_LAT  = 1;
    localparam int TIMEOUT = 100;
    localparam int DEF_CLIP = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       fx_valid;
    logic [7:0] fx_byte;
    logic       clip_en;
    logic [7:0] clip_level;
    logic [7:0] fx_in;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_busy;
    logic       overrun;
    logic       cmd_err;
    logic       busy;

    int n_checks = 0;
    int n_fails  = 0;

    fx_cmd_sequencer #(
        .CLK_FREQ       (50_000_000),
        .DEFAULT_CLIP   (DEF_CLIP),
        .FX_LATENCY     (FX_LAT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_valid   (rx_valid),
        .i_rx_byte    (rx_byte),
        .o_fx_valid   (fx_valid),
        .o_fx_byte    (fx_byte),
        .o_clip_en    (clip_en),
        .o_clip_level (clip_level),
        .i_fx_byte    (fx_in),
        .o_tx_start   (tx_start),
        .o_tx_byte    (tx_byte),
        .i_tx_busy    (tx_busy),
        .o_overrun    (overrun),
        .o_cmd_err    (cmd_err),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    // Effect model: clip to level, FX_LAT cycles after the strobe; noise otherwise
    logic [7:0] fx_pipe [FX_LAT];
    logic       vld_pipe [FX_LAT];
    logic [7:0] noise;
    always @(posedge clk) begin
        vld_pipe[0] <= fx_valid;
        fx_pipe[0]  <= (fx_byte < clip_level) ? fx_byte : clip_level;
        for (int i = 1; i < FX_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            fx_pipe[i]  <= fx_pipe[i-1];
        end
        noise <= 8'($urandom);
    end
    assign fx_in = (vld_pipe[FX_LAT-1] === 1'b1) ? fx_pipe[FX_LAT-1] : noise;

    // Reference model state (protocol level, timestamps instead of counters)
    int         m_cyc;
    int         m_mode;       // 0 normal, 1 after escape, 2 awaiting argument
    int         m_op;
    int         m_idle;
    bit         m_inflight;
    int         m_acc;
    logic [7:0] m_fx, m_tx, m_level;
    bit         m_en, m_over, m_err;

    bit         tx_seen;
    logic [7:0] tx_seen_byte;
    int         tx_seen_cyc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_op = 0; m_idle = 0; m_inflight = 0; m_acc = -100;
        m_fx = 8'h00; m_tx = 8'h00; m_level = 8'(DEF_CLIP);
        m_en = 1'b1; m_over = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] s);
        m_inflight = 1'b1;
        m_acc      = m_cyc;
        m_fx       = s;
        m_mode     = 0;
    endtask

    task automatic model_cycle(input logic v, input logic [7:0] b, input logic bz);
        bit exp_start;
        exp_start = m_inflight && (m_cyc >= m_acc + 2 + FX_LAT) && !bz;
        check_eq("fx_valid", fx_valid, (m_inflight && m_cyc == m_acc + 1));
        check_eq("fx_byte", fx_byte, m_fx);
        check_eq("tx_start", tx_start, exp_start);
        check_eq("tx_byte", tx_byte, m_tx);
        check_eq("clip_en", clip_en, m_en);
        check_eq("clip_level", clip_level, m_level);
        check_eq("overrun", overrun, m_over);
        check_eq("cmd_err", cmd_err, m_err);
        check_eq("busy", busy, (m_mode != 0) || m_inflight);
        if (tx_start === 1'b1) begin
            tx_seen      = 1'b1;
            tx_seen_byte = tx_byte;
            tx_seen_cyc  = m_cyc;
        end
        if (m_inflight) begin
            if (v) m_over = 1'b1;
            if (m_cyc == m_acc + 1 + FX_LAT)
                m_tx = !m_en ? m_fx : ((m_fx < m_level) ? m_fx : m_level);
            if (exp_start) m_inflight = 1'b0;
        end else if (m_mode == 0) begin
            if (v) begin
                if (b == 8'hFF) begin
                    m_mode = 1;
                    m_idle = 0;
                end else begin
                    model_accept(b);
                end
            end
        end else if (v) begin
            m_idle = 0;
            if (m_mode == 1) begin
                if (b == 8'hFF) model_accept(8'hFF);
                else if (b == 8'h01 || b == 8'h02) begin m_op = int'(b); m_mode = 2; end
                else if (b == 8'h03) begin m_over = 1'b0; m_err = 1'b0; m_mode = 0; end
                else begin m_err = 1'b1; m_mode = 0; end
            end else begin
                if (m_op == 1) m_en = b[0];
                else m_level = b;
                m_mode = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_mode = 0;
                m_err  = 1'b1;
            end
        end
        m_cyc++;
    endtask

    task automatic cycle(input logic v, input logic [7:0] b, input logic bz);
        @(negedge clk);
        rst = 1'b0; rx_valid = v; rx_byte = b; tx_busy = bz;
        #1;
        model_cycle(v, b, bz);
    endtask

    task automatic do_reset(input logic bz);
        @(negedge clk);
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_busy = bz;
        #1;
        check_eq("tx_start_in_reset", tx_start, 1'b0);
        model_reset();
        m_cyc++;
    endtask

    task automatic send_expect(input string tag, input logic [7:0] b, input logic [7:0] exp);
        int c0;
        c0 = m_cyc;
        tx_seen = 1'b0;
        cycle(1'b1, b, 1'b0);
        for (int i = 0; i < 20 && !tx_seen; i++) cycle(1'b0, 8'h00, 1'b0);
        check_eq({tag, "_seen"}, tx_seen, 1'b1);
        check_eq(tag, tx_seen_byte, exp);
        check_eq({tag, "_lat"}, tx_seen_cyc - c0, 2 + FX_LAT);
    endtask

    task automatic cmd(input logic [7:0] b);
        cycle(1'b1, b, 1'b0);
    endtask

    function automatic logic [7:0] rand_byte();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2: rand_byte = 8'hFF;
            3:       rand_byte = 8'h01;
            4:       rand_byte = 8'h02;
            5:       rand_byte = 8'h03;
            6:       rand_byte = 8'h07;
            default: rand_byte = 8'($urandom);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  c0;
        logic rb;
        rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; tx_busy = 1'b0;
        m_cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        do_reset(1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("rst_level", clip_level, 8'd200);
        check_eq("rst_en", clip_en, 1'b1);

        send_expect("s150", 8'd150, 8'd150);
        send_expect("s250_clip", 8'd250, 8'd200);

        cmd(8'hFF); cmd(8'h02); cmd(8'hB4);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("level_b4", clip_level, 8'd180);
        send_expect("s250_lvl180", 8'd250, 8'd180);

        cmd(8'hFF); cmd(8'h01); cmd(8'h00);
        send_expect("s250_bypass", 8'd250, 8'd250);

        cmd(8'hFF); cmd(8'h01); cmd(8'h01);
        cmd(8'hFF); cmd(8'h02); cmd(8'hC8);
        cmd(8'hFF);
        send_expect("ffff", 8'hFF, 8'd200);
        check_eq("ffff_err", cmd_err, 1'b0);

        // Back-pressure: busy for 10 cycles, a dropped byte in the middle
        c0 = m_cyc;
        tx_seen = 1'b0;
        cycle(1'b1, 8'h55, 1'b1);
        for (int i = 1; i <= 10; i++) cycle(i == 4, 8'h20, 1'b1);
        check_eq("bp_no_start", tx_seen, 1'b0);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("bp_seen", tx_seen, 1'b1);
        check_eq("bp_byte", tx_seen_byte, 8'h55);
        check_eq("bp_when", tx_seen_cyc - c0, 11);
        check_eq("bp_overrun", overrun, 1'b1);
        cmd(8'hFF); cmd(8'h03);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("ovr_cleared", overrun, 1'b0);

        cmd(8'hFF); cmd(8'h07);
        cycle(1'b0, 8'h00, 1'b0);
        check_eq("bad_op_err", cmd_err, 1'b1);
        check_eq("bad_op_level", clip_level, 8'd200);
        check_eq("bad_op_en", clip_en, 1'b1);

        // Escape followed by silence must time out
        cmd(8'hFF); cmd(8'h03);
        cmd(8'hFF);
        n = 0;
        do begin
            cycle(1'b0, 8'h00, 1'b0);
            n++;
        end while (busy && n < 300);
        check_eq("timeout_len", n, TIMEOUT + 1);
        check_eq("timeout_err", cmd_err, 1'b1);
        send_expect("after_to", 8'h10, 8'h10);

        // Reset while a byte sits in SEND
        cmd(8'hFF); cmd(8'h02); cmd(8'h64);
        tx_seen = 1'b0;
        cycle(1'b1, 8'h90, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1);
        check_eq("pend_busy", busy, 1'b1);
        check_eq("pend_byte", tx_byte, 8'd100);
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b0);
        check_eq("mrst_no_start", tx_seen, 1'b0);
        check_eq("mrst_level", clip_level, 8'd200);
        check_eq("mrst_busy", busy, 1'b0);

        // Random byte streams with random back-pressure
        rb = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 700 == 350) begin
                for (int j = 0; j < 120; j++) cycle(1'b0, 8'h00, 1'b0);
            end
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            cycle($urandom_range(0, 2) == 0, rand_byte(), rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
